mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_rr_arb2.sv | 44 ++++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter.
// - state_t : top-level FSM state (BOOT, RUN, LOCK)
// - owner_t : requester identifier, also used as the registered read-owner tag
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        LOCK = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        INSTR  = 2'd1,
        DATA   = 2'd2,
        LOADER = 2'd3
    } owner_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a last-winner register.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   en         arbitration allowed this cycle (no grant when low)
//   reqA/reqB  requests (A = instruction, B = data)
//   gntA/gntB  combinational grants, at most one high
// Under contention the requester that did not win last time is granted.
// The last-winner register resets to "A won", so B is favoured first,
// and only moves when a grant is actually issued.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic reqA,
    input  logic reqB,
    output logic gntA,
    output logic gntB
);

    logic lastB;

    always_comb begin
        gntA = 1'b0;
        gntB = 1'b0;
        if (en) begin
            if (reqA && reqB) begin
                gntA = lastB;
                gntB = !lastB;
            end else begin
                gntA = reqA;
                gntB = reqB;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastB <= 1'b0;
        end else if (gntA || gntB) begin
            lastB <= gntB;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM between an instruction fetch port,
// a data port and an image loader.
// Handshake: a requester raises *_req with its address/data stable; the
// transfer happens in the cycle where *_req and *_gnt are both high
// (grant is combinational). The requester keeps *_req high until granted.
// Reads return mem_rdata one cycle after the grant, flagged by *_rvalid.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   i_req/i_addr/i_gnt          instruction fetch (read only)
//   i_rvalid/i_rdata            fetch data return
//   d_req/d_we/d_addr/d_wdata   data port, d_gnt accept
//   d_rvalid/d_rdata            data read return
//   l_req/l_addr/l_wdata/l_done loader writes and load-complete pulse, l_gnt accept
//   mem_addr/mem_we/mem_wdata   RAM request, mem_rdata registered RAM output
//   cpu_run                     processor may run (RUN or LOCK)
//   dbgState                    current FSM state (state_t encoding)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    input  logic          l_req,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    input  logic          l_done,
    output logic          l_gnt,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_run,
    output logic [1:0]    dbgState
);

    state_t state, stateNext;
    owner_t rdTag, rdTagNext;
    logic   arbEn;

    rr_arb2 uRrArb (
        .clk  (clk),
        .rst  (rst),
        .en   (arbEn),
        .reqA (i_req),
        .reqB (d_req),
        .gntA (i_gnt),
        .gntB (d_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            rdTag <= NONE;
        end else begin
            state <= stateNext;
            rdTag <= rdTagNext;
        end
    end

    // Loader is served in every state; i/d arbitration only in RUN
    // and only when the loader is not asking.
    always_comb begin
        stateNext = state;
        l_gnt     = l_req;
        arbEn     = 1'b0;
        cpu_run   = 1'b1;
        unique case (state)
            BOOT: begin
                cpu_run = 1'b0;
                if (l_done) stateNext = RUN;
            end
            RUN: begin
                arbEn = !l_req;
                if (l_req) stateNext = LOCK;
            end
            LOCK: begin
                if (!l_req) stateNext = RUN;
            end
            default: begin
                stateNext = BOOT;
                l_gnt     = 1'b0;
                cpu_run   = 1'b0;
            end
        endcase
    end

    // RAM request mux; idle cycles drive all zeros.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        rdTagNext = NONE;
        if (l_gnt) begin
            mem_addr  = l_addr;
            mem_we    = 1'b1;
            mem_wdata = l_wdata;
        end else if (i_gnt) begin
            mem_addr  = i_addr;
            rdTagNext = INSTR;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_we    = d_we;
            mem_wdata = d_wdata;
            rdTagNext = d_we ? NONE : DATA;
        end
    end

    // The tag is rewritten every cycle, so an rvalid is a single-cycle
    // pulse and a new grant never masks the one already in flight.
    assign i_rvalid = (rdTag == INSTR);
    assign d_rvalid = (rdTag == DATA);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign dbgState = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered RAM.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          l_req, l_done, l_gnt;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          cpu_run;
    logic [1:0]    dbgState;

    int nChecks = 0;
    int nErr    = 0;

    logic [DW-1:0] ram [256];

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_done(l_done), .l_gnt(l_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_run(cpu_run), .dbgState(dbgState)
    );

    // Registered single-port RAM, read-before-write.
    initial begin
        for (int k = 0; k < 256; k++) ram[k] = '0;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        l_req = 0; l_addr = '0; l_wdata = '0; l_done = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_l_gnt", l_gnt, 0);
        chk("rst_i_rvalid", i_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_cpu_run", cpu_run, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_state", dbgState, BOOT);
        @(negedge clk);
        rst = 1'b0;

        // Boot image load, fetch request ignored throughout
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            i_req = 1; i_addr = 16'h0040;
            l_req = 1; l_addr = AW'(n); l_wdata = DW'(16'hA000 + n);
            #1;
            chk("boot_l_gnt", l_gnt, 1);
            chk("boot_i_gnt", i_gnt, 0);
            chk("boot_mem_we", mem_we, 1);
            chk("boot_mem_addr", mem_addr, n);
            chk("boot_mem_wdata", mem_wdata, 32'hA000 + n);
            chk("boot_cpu_run", cpu_run, 0);
        end
        @(negedge clk);
        l_req = 0; l_done = 1;
        #1;
        chk("done_i_gnt", i_gnt, 0);
        chk("done_l_gnt", l_gnt, 0);
        chk("done_mem_we", mem_we, 0);
        chk("done_cpu_run", cpu_run, 0);
        @(negedge clk);
        l_done = 0; i_req = 0;
        #1;
        chk("run_cpu_run", cpu_run, 1);
        chk("run_state", dbgState, RUN);

        // Contention: D, I, D, I with rvalids one cycle behind
        @(negedge clk);
        i_req = 1; i_addr = 16'h0002;
        d_req = 1; d_we = 0; d_addr = 16'h0001;
        #1;
        chk("rr1_d_gnt", d_gnt, 1);
        chk("rr1_i_gnt", i_gnt, 0);
        chk("rr1_mem_addr", mem_addr, 16'h0001);
        chk("rr1_mem_we", mem_we, 0);
        @(negedge clk); #1;
        chk("rr2_i_gnt", i_gnt, 1);
        chk("rr2_d_gnt", d_gnt, 0);
        chk("rr2_mem_addr", mem_addr, 16'h0002);
        chk("rr2_d_rvalid", d_rvalid, 1);
        chk("rr2_i_rvalid", i_rvalid, 0);
        chk("rr2_d_rdata", d_rdata, 16'hA001);
        @(negedge clk); #1;
        chk("rr3_d_gnt", d_gnt, 1);
        chk("rr3_i_rvalid", i_rvalid, 1);
        chk("rr3_d_rvalid", d_rvalid, 0);
        chk("rr3_i_rdata", i_rdata, 16'hA002);
        @(negedge clk); #1;
        chk("rr4_i_gnt", i_gnt, 1);
        chk("rr4_d_rvalid", d_rvalid, 1);
        chk("rr4_d_rdata", d_rdata, 16'hA001);
        @(negedge clk);
        i_req = 0; d_req = 0;
        #1;
        chk("rr5_i_rvalid", i_rvalid, 1);
        chk("rr5_i_rdata", i_rdata, 16'hA002);
        chk("idle_gnts", {i_gnt, d_gnt, l_gnt}, 0);
        chk("idle_mem_addr", mem_addr, 0);
        chk("idle_mem_wdata", mem_wdata, 0);
        @(negedge clk); #1;
        chk("idle_rvalids", {i_rvalid, d_rvalid}, 0);

        // Single fetch
        @(negedge clk);
        i_req = 1; i_addr = 16'h0010;
        #1;
        chk("if_i_gnt", i_gnt, 1);
        chk("if_mem_addr", mem_addr, 16'h0010);
        @(negedge clk);
        i_req = 0;
        #1;
        chk("if_i_rvalid", i_rvalid, 1);
        chk("if_i_rdata", i_rdata, 16'h0000);

        // Data write then read back
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
        #1;
        chk("dw_d_gnt", d_gnt, 1);
        chk("dw_mem_we", mem_we, 1);
        chk("dw_mem_addr", mem_addr, 16'h0020);
        chk("dw_mem_wdata", mem_wdata, 16'h1234);
        @(negedge clk);
        d_we = 0;
        #1;
        chk("dr_d_gnt", d_gnt, 1);
        chk("dr_mem_we", mem_we, 0);
        chk("dr_no_rvalid_for_write", d_rvalid, 0);
        @(negedge clk);
        d_req = 0;
        #1;
        chk("dr_d_rvalid", d_rvalid, 1);
        chk("dr_d_rdata", d_rdata, 16'h1234);
        @(negedge clk); #1;
        chk("dr_rvalid_once", d_rvalid, 0);

        // Loader burst in RUN during i/d contention
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_req = 1; i_addr = 16'h0002;
            d_req = 1; d_we = 0; d_addr = 16'h0001;
            l_req = 1; l_addr = AW'(16'h0030 + k); l_wdata = 16'h7777;
            #1;
            chk("lk_l_gnt", l_gnt, 1);
            chk("lk_id_gnt", {i_gnt, d_gnt}, 0);
            chk("lk_mem_we", mem_we, 1);
            chk("lk_mem_addr", mem_addr, 16'h0030 + k);
            chk("lk_cpu_run", cpu_run, 1);
        end
        @(negedge clk);
        l_req = 0;
        #1;
        chk("lk_fall_gnts", {i_gnt, d_gnt, l_gnt}, 0);
        chk("lk_fall_state", dbgState, LOCK);
        chk("lk_fall_cpu_run", cpu_run, 1);
        @(negedge clk); #1;
        chk("lk_after_i_gnt", i_gnt, 1);
        chk("lk_after_d_gnt", d_gnt, 0);
        chk("lk_after_state", dbgState, RUN);
        @(negedge clk);
        i_req = 0; d_req = 0;
        #1;
        chk("lk_after_i_rvalid", i_rvalid, 1);
        chk("lk_after_i_rdata", i_rdata, 16'hA002);

        // Reset right after a read grant kills the pending rvalid
        @(negedge clk);
        i_req = 1; i_addr = 16'h0003;
        #1;
        chk("rr_i_gnt", i_gnt, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rr_gnt_in_rst", i_gnt, 0);
        i_req = 0;
        @(negedge clk); #1;
        chk("rr_no_rvalid", i_rvalid, 0);
        chk("rr_state", dbgState, BOOT);
        chk("rr_cpu_run", cpu_run, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("post_rst_rvalids", {i_rvalid, d_rvalid}, 0);
        end

        // Loader write and l_done in the same BOOT cycle
        @(negedge clk);
        l_req = 1; l_addr = 16'h0005; l_wdata = 16'h5555; l_done = 1;
        #1;
        chk("ld_l_gnt", l_gnt, 1);
        chk("ld_mem_we", mem_we, 1);
        chk("ld_cpu_run", cpu_run, 0);
        @(negedge clk);
        l_req = 0; l_done = 0;
        #1;
        chk("ld_run", cpu_run, 1);
        chk("ld_state", dbgState, RUN);
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 16'h0005;
        #1;
        chk("ld_rb_d_gnt", d_gnt, 1);
        @(negedge clk);
        d_req = 0;
        #1;
        chk("ld_rb_d_rvalid", d_rvalid, 1);
        chk("ld_rb_d_rdata", d_rdata, 16'h5555);

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule
